// File: rtl/ti_share_stage_buf_if.sv
// Handshake bundle between round-1 producer, the glitch-barrier stage and round-2 consumers.
// The master drives vectors, randomness and consumer ready; the slave is the stage itself.
interface ti_share_stage_buf_if #(
    parameter int WIDTH  = 8,
    parameter int SHARES = 2
);
    localparam int SW = WIDTH / SHARES;
    localparam int RW = SW * (SHARES - 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_shares;
    logic             rnd_valid;
    logic [RW-1:0]    rnd;
    logic             rnd_ack;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_shares;
    logic [1:0]       occupancy;

    modport master (
        output flush, in_valid, in_shares, rnd_valid, rnd, out_ready,
        input  in_ready, rnd_ack, out_valid, out_shares, occupancy
    );

    modport slave (
        input  flush, in_valid, in_shares, rnd_valid, rnd, out_ready,
        output in_ready, rnd_ack, out_valid, out_shares, occupancy
    );
endinterface

// File: rtl/ti_share_stage_buf.sv
// Two-entry glitch-barrier buffer between TI S-box rounds; shares leave straight from flops
// and are never combined with each other, only with fresh mask slices on write.
module ti_share_stage_buf #(
    parameter int WIDTH  = 8,
    parameter int SHARES = 2,
    parameter bit REMASK = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    ti_share_stage_buf_if.slave bus
);
    localparam int SW = WIDTH / SHARES;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_live;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;

    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [SW-1:0]    w_rnd_sum;
    logic [WIDTH-1:0] w_masked;

    // r_live keeps in_ready low until the first edge after reset release.
    assign w_in_ready = r_live & (r_state != FULL) & ~bus.flush;
    assign w_push     = bus.in_valid & w_in_ready & (bus.rnd_valid | ~REMASK);
    assign w_pop      = (r_state != EMPTY) & bus.out_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_rnd_sum = '0;
        w_masked  = bus.in_shares;
        if (REMASK) begin
            for (int i = 0; i < SHARES - 1; i++) begin
                w_masked[i*SW +: SW] = bus.in_shares[i*SW +: SW] ^ bus.rnd[i*SW +: SW];
                w_rnd_sum            = w_rnd_sum ^ bus.rnd[i*SW +: SW];
            end
            // Last share absorbs every slice so the XOR over all shares is unchanged.
            w_masked[(SHARES-1)*SW +: SW] = bus.in_shares[(SHARES-1)*SW +: SW] ^ w_rnd_sum;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.rnd_ack    = REMASK & w_push;
    assign bus.out_valid  = (r_state != EMPTY);
    assign bus.out_shares = r_head;
    assign bus.occupancy  = r_state;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the entry storage is reset on purpose; no share material may survive a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_live  <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_live <= 1'b1;
            if (bus.flush) begin
                r_state <= EMPTY;
                r_head  <= '0;
                r_tail  <= '0;
            end else begin
                unique case (r_state)
                    EMPTY: begin
                        if (w_push) begin
                            r_head  <= w_masked;
                            r_state <= ONE;
                        end
                    end
                    ONE: begin
                        if (w_push && w_pop) begin
                            r_head <= w_masked;
                        end else if (w_push) begin
                            r_tail  <= w_masked;
                            r_state <= FULL;
                        end else if (w_pop) begin
                            r_head  <= '0;
                            r_state <= EMPTY;
                        end
                    end
                    FULL: begin
                        // Popped head is overwritten; the vacated tail slot is scrubbed.
                        if (w_pop) begin
                            r_head  <= r_tail;
                            r_tail  <= '0;
                            r_state <= ONE;
                        end
                    end
                    default: r_state <= EMPTY;
                endcase
            end
        end
    end
endmodule
